// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, MIPS field positions and helpers.
// The HALT state exists only when SYSCALL_HALT_EN is defined.
package fetch_pkg;

`ifdef SYSCALL_HALT_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;
`endif

  localparam logic [5:0]  OPC_RTYPE    = 6'b000000;
  localparam logic [5:0]  FUNC_SYSCALL = 6'b001100;
  localparam logic [31:0] PC_STEP      = 32'd4;

  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 26;
  localparam int unsigned FUNC_MSB = 5;
  localparam int unsigned FUNC_LSB = 0;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_syscall(input logic [31:0] word);
    return (word[OPC_MSB:OPC_LSB] == OPC_RTYPE) && (word[FUNC_MSB:FUNC_LSB] == FUNC_SYSCALL);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory handshake, decoder stream and redirect.
interface inst_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  func;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid, inst_word, inst_pc, opcode, func,
    input  inst_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid, inst_word, inst_pc, opcode, func,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc,word}; flush beats push and pop.
module inst_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end with prefetch buffer and redirect handling.
// Optional SYSCALL_HALT_EN: a popped SYSCALL parks fetch until resume.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  inst_fetch_unit_if.master bus
`ifdef SYSCALL_HALT_EN
  ,
  output logic halted,
  input  logic resume
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;

  logic          push, pop, flush, ack, hold;
  logic [31:0]   redir_pc;
  logic [63:0]   head;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   head_word, head_pc;
  logic          head_valid;

  inst_fifo #(
    .WIDTH (64),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pc_q, bus.imem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign head_word  = head[31:0];
  assign head_pc    = head[63:32];
  assign head_valid = (count != '0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = head_valid && bus.inst_ready;
    ack       = req_q && bus.imem_ack;
    hold      = req_q && !ack;
    redir_pc  = align_pc(bus.redirect_pc);
    count_nxt = count;

    case (state_q)
      ST_IDLE: begin
        if (bus.redirect_valid) pc_d = redir_pc;
        state_d = ST_FETCH;
        req_d   = 1'b1;
        addr_d  = pc_d;
      end

      ST_FETCH: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          pc_d  = redir_pc;
          // an unacked request keeps its address; its data is dropped in DISCARD
          if (hold) begin
            state_d = ST_DISCARD;
          end else begin
            req_d  = 1'b1;
            addr_d = redir_pc;
          end
`ifdef SYSCALL_HALT_EN
        end else if (pop && is_syscall(head_word)) begin
          flush   = 1'b1;
          pc_d    = head_pc + PC_STEP;
          state_d = ST_HALT;
          req_d   = hold;
          if (!hold) addr_d = pc_d;
`endif
        end else begin
          push = ack;
          if (ack) pc_d = pc_q + PC_STEP;
          count_nxt = count + CW'(push) - CW'(pop);
          if (!hold) begin
            req_d  = (count_nxt < CW'(BUF_DEPTH));
            addr_d = pc_d;
          end
        end
      end

      ST_DISCARD: begin
        if (bus.redirect_valid) pc_d = redir_pc;
        if (ack) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          addr_d  = pc_d;
        end
      end

`ifdef SYSCALL_HALT_EN
      ST_HALT: begin
        if (bus.redirect_valid) pc_d = redir_pc;
        req_d = hold;
        if (resume) begin
          if (hold) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_d;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst_word  = head_word;
  assign bus.inst_pc    = head_pc;
  assign bus.opcode     = head_word[OPC_MSB:OPC_LSB];
  assign bus.func       = head_word[FUNC_MSB:FUNC_LSB];

`ifdef SYSCALL_HALT_EN
  assign halted = (state_q == ST_HALT);
`endif

endmodule
